// File: rtl/dual_port_ram_param.sv
// True dual-port RAM, single clock, self-clearing after reset, with deterministic collision handling.
// Optional macro DPRAM_OUT_REG_EN adds one output register stage (read latency 2).
module dual_port_ram_param #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_in_1,
    input  logic                  write_en_1,
    input  logic [ADDR_WIDTH-1:0] address_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  valid_out_1,
    input  logic                  enable_in_2,
    input  logic                  write_en_2,
    input  logic [ADDR_WIDTH-1:0] address_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic                  valid_out_2,
    output logic                  init_busy,
    output logic                  collision_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    init_busy_q, init_busy_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    req1, req2, wr1, wr2, same_addr;
    logic                    mem_we_a, mem_we_b;
    logic [ADDR_WIDTH-1:0]   mem_addr_a;
    logic [DATA_WIDTH-1:0]   mem_wdata_a;
    logic [DATA_WIDTH-1:0]   old1, old2, new1, new2, rd1, rd2;

    logic [DATA_WIDTH-1:0]   data1_q, data1_d, data2_q, data2_d;
    logic                    valid1_q, valid1_d, valid2_q, valid2_d;
    logic                    collision_q, collision_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_d = init_busy_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d     = ST_RUN;
                init_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    always_comb begin
        req1      = (state_q == ST_RUN) && enable_in_1;
        req2      = (state_q == ST_RUN) && enable_in_2;
        wr1       = req1 && write_en_1;
        wr2       = req2 && write_en_2;
        same_addr = (address_in_1 == address_in_2);
    end

    // Write port A is shared by the clear sequencer and port 1; port 2 loses a same-address write.
    always_comb begin
        if (state_q == ST_INIT) begin
            mem_we_a    = 1'b1;
            mem_addr_a  = cnt_q;
            mem_wdata_a = CLEAR_VALUE;
        end else begin
            mem_we_a    = wr1;
            mem_addr_a  = address_in_1;
            mem_wdata_a = data_in_1;
        end
        mem_we_b = wr2 && !(wr1 && same_addr);
    end

    always_ff @(posedge clk) begin
        if (mem_we_a) begin
            mem[mem_addr_a] <= mem_wdata_a;
        end
        if (mem_we_b) begin
            mem[address_in_2] <= data_in_2;
        end
    end

    // "new" is whatever word will actually be stored at that port's address this cycle.
    always_comb begin
        old1 = mem[address_in_1];
        old2 = mem[address_in_2];

        new1 = old1;
        if (wr1) begin
            new1 = data_in_1;
        end else if (wr2 && same_addr) begin
            new1 = data_in_2;
        end

        new2 = old2;
        if (wr1 && same_addr) begin
            new2 = data_in_1;
        end else if (wr2) begin
            new2 = data_in_2;
        end

        if (RDW_MODE != 0) begin
            rd1 = new1;
            rd2 = new2;
        end else begin
            rd1 = old1;
            rd2 = old2;
        end
    end

    always_comb begin
        data1_d  = data1_q;
        valid1_d = 1'b0;
        if (req1) begin
            data1_d  = rd1;
            valid1_d = 1'b1;
        end

        data2_d  = data2_q;
        valid2_d = 1'b0;
        if (req2) begin
            data2_d  = rd2;
            valid2_d = 1'b1;
        end

        collision_d = req1 && req2 && same_addr && (write_en_1 || write_en_2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1_q     <= '0;
            valid1_q    <= 1'b0;
            data2_q     <= '0;
            valid2_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            data1_q     <= data1_d;
            valid1_q    <= valid1_d;
            data2_q     <= data2_d;
            valid2_q    <= valid2_d;
            collision_q <= collision_d;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_data1_q, out_data1_d, out_data2_q, out_data2_d;
    logic                  out_valid1_q, out_valid2_q, out_collision_q;

    always_comb begin
        out_data1_d = valid1_q ? data1_q : out_data1_q;
        out_data2_d = valid2_q ? data2_q : out_data2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data1_q     <= '0;
            out_data2_q     <= '0;
            out_valid1_q    <= 1'b0;
            out_valid2_q    <= 1'b0;
            out_collision_q <= 1'b0;
        end else begin
            out_data1_q     <= out_data1_d;
            out_data2_q     <= out_data2_d;
            out_valid1_q    <= valid1_q;
            out_valid2_q    <= valid2_q;
            out_collision_q <= collision_q;
        end
    end

    assign data_out_1    = out_data1_q;
    assign valid_out_1   = out_valid1_q;
    assign data_out_2    = out_data2_q;
    assign valid_out_2   = out_valid2_q;
    assign collision_out = out_collision_q;
`else
    assign data_out_1    = data1_q;
    assign valid_out_1   = valid1_q;
    assign data_out_2    = data2_q;
    assign valid_out_2   = valid2_q;
    assign collision_out = collision_q;
`endif

    assign init_busy = init_busy_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Self-checking bench for dual_port_ram_param: directed scenarios plus randomized traffic
// against an array-based reference model of the memory and its output timing.
module tb_dual_port_ram_param;

    localparam int         RDW   = 0;
    localparam logic [7:0] CLEAR = 8'h00;
    localparam int         DEPTH = 256;
`ifdef DPRAM_OUT_REG_EN
    localparam int         LAT   = 2;
`else
    localparam int         LAT   = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_in_1 = 1'b0, write_en_1 = 1'b0;
    logic [7:0] address_in_1 = '0, data_in_1 = '0;
    logic       enable_in_2 = 1'b0, write_en_2 = 1'b0;
    logic [7:0] address_in_2 = '0, data_in_2 = '0;
    logic [7:0] data_out_1, data_out_2;
    logic       valid_out_1, valid_out_2, init_busy, collision_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_port_ram_param #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .RDW_MODE   (RDW),
        .CLEAR_VALUE(CLEAR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_in_1  (enable_in_1),
        .write_en_1   (write_en_1),
        .address_in_1 (address_in_1),
        .data_in_1    (data_in_1),
        .data_out_1   (data_out_1),
        .valid_out_1  (valid_out_1),
        .enable_in_2  (enable_in_2),
        .write_en_2   (write_en_2),
        .address_in_2 (address_in_2),
        .data_in_2    (data_in_2),
        .data_out_2   (data_out_2),
        .valid_out_2  (valid_out_2),
        .init_busy    (init_busy),
        .collision_out(collision_out)
    );

    // Reference model: memory image, remaining clear cycles, and the response of each
    // cycle delayed by the read latency.
    logic [7:0] mem_m [DEPTH];
    int         init_left;
    logic [7:0] s1_d1, s1_d2, s2_d1, s2_d2;
    logic       s1_v1, s1_v2, s1_col, s2_v1, s2_v2, s2_col;
    logic [7:0] exp_d1, exp_d2;
    logic       exp_v1, exp_v2, exp_col, exp_busy;

    function automatic void model_reset();
        init_left = DEPTH;
        s1_d1 = '0; s1_d2 = '0; s1_v1 = 0; s1_v2 = 0; s1_col = 0;
        s2_d1 = '0; s2_d2 = '0; s2_v1 = 0; s2_v2 = 0; s2_col = 0;
        exp_d1 = '0; exp_d2 = '0; exp_v1 = 0; exp_v2 = 0; exp_col = 0; exp_busy = 1;
    endfunction

    task automatic step(input logic e1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                        input logic e2, input logic w2, input logic [7:0] a2, input logic [7:0] d2);
        logic [7:0] r1, r2;
        enable_in_1 = e1; write_en_1 = w1; address_in_1 = a1; data_in_1 = d1;
        enable_in_2 = e2; write_en_2 = w2; address_in_2 = a2; data_in_2 = d2;
        @(posedge clk);
        s2_d1 = s1_v1 ? s1_d1 : s2_d1; s2_v1 = s1_v1;
        s2_d2 = s1_v2 ? s1_d2 : s2_d2; s2_v2 = s1_v2;
        s2_col = s1_col;
        if (init_left > 0) begin
            init_left--;
            s1_v1 = 0; s1_v2 = 0; s1_col = 0;
            if (init_left == 0) begin
                foreach (mem_m[i]) mem_m[i] = CLEAR;
            end
        end else begin
            r1 = mem_m[a1];
            r2 = mem_m[a2];
            if (e2 && w2) mem_m[a2] = d2;
            if (e1 && w1) mem_m[a1] = d1;   // port 1 wins a same-address double write
            if (RDW != 0) begin
                r1 = mem_m[a1];
                r2 = mem_m[a2];
            end
            s1_v1 = e1; if (e1) s1_d1 = r1;
            s1_v2 = e2; if (e2) s1_d2 = r2;
            s1_col = e1 && e2 && (a1 == a2) && (w1 || w2);
        end
`ifdef DPRAM_OUT_REG_EN
        exp_d1 = s2_d1; exp_v1 = s2_v1; exp_d2 = s2_d2; exp_v2 = s2_v2; exp_col = s2_col;
`else
        exp_d1 = s1_d1; exp_v1 = s1_v1; exp_d2 = s1_d2; exp_v2 = s1_v2; exp_col = s1_col;
`endif
        exp_busy = (init_left > 0);
        #1;
    endtask

    task automatic step_idle();
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({data_out_1, data_out_2} !== 16'h0000 || {valid_out_1, valid_out_2, collision_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got d1=%h d2=%h v1=%b v2=%b col=%b, expected all 0",
                     data_out_1, data_out_2, valid_out_1, valid_out_2, collision_out);
        end
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 1", init_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        int n = 0;
        while (init_busy === 1'b1 && n < 300) begin
            step_idle();
            n++;
            checks++;
            if (init_busy !== exp_busy || valid_out_1 !== 1'b0) begin
                errors++;
                $display("FAIL init_cycle %0d: busy=%b v1=%b, expected busy=%b v1=0", n, init_busy, valid_out_1, exp_busy);
            end
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_length: busy lasted %0d cycles, expected %0d", n, DEPTH);
        end
        step(1, 0, 8'h7F, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (LAT - 1) step_idle();
        checks++;
        if (data_out_1 !== 8'h00 || valid_out_1 !== 1'b1) begin
            errors++;
            $display("FAIL init_read_7f: got d1=%h v1=%b, expected 00 1", data_out_1, valid_out_1);
        end
    endtask

    task automatic test_write_read();
        step(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        step(0, 1, 8'h10, 8'hFF, 1, 0, 8'h10, 8'h00);
`ifdef DPRAM_OUT_REG_EN
        checks++;
        if (valid_out_2 !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_early_valid: got v2=%b expected 0 one clk after request", valid_out_2);
        end
`endif
        repeat (LAT - 1) step_idle();
        checks++;
        if (data_out_2 !== 8'hA5 || valid_out_2 !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_p2: got d2=%h v2=%b, expected a5 1", data_out_2, valid_out_2);
        end
        step_idle();
        checks++;
        if (valid_out_2 !== 1'b0 || data_out_2 !== 8'hA5) begin
            errors++;
            $display("FAIL wr_rd_pulse: got d2=%h v2=%b, expected a5 0 (held data)", data_out_2, valid_out_2);
        end
    endtask

    task automatic test_collision_ww();
        step(1, 1, 8'h20, 8'h11, 1, 1, 8'h20, 8'h22);
        repeat (LAT - 1) step_idle();
        checks++;
        if (collision_out !== 1'b1 || data_out_2 !== ((RDW != 0) ? 8'h11 : 8'h00)) begin
            errors++;
            $display("FAIL ww_collision: got col=%b d2=%h, expected 1 %h", collision_out, data_out_2,
                     (RDW != 0) ? 8'h11 : 8'h00);
        end
        step_idle();
        checks++;
        if (collision_out !== 1'b0) begin
            errors++;
            $display("FAIL ww_col_pulse: got %b expected 0", collision_out);
        end
        step(1, 0, 8'h20, 8'h00, 1, 0, 8'h20, 8'h00);
        repeat (LAT - 1) step_idle();
        checks++;
        if (data_out_1 !== 8'h11 || data_out_2 !== 8'h11 || collision_out !== 1'b0) begin
            errors++;
            $display("FAIL ww_stored: got d1=%h d2=%h col=%b, expected 11 11 0", data_out_1, data_out_2, collision_out);
        end
    endtask

    task automatic test_collision_rw();
        step(1, 1, 8'h30, 8'h3C, 1, 0, 8'h30, 8'h00);
        repeat (LAT - 1) step_idle();
        checks++;
        if (data_out_2 !== ((RDW != 0) ? 8'h3C : 8'h00) || collision_out !== 1'b1) begin
            errors++;
            $display("FAIL rw_collision: got d2=%h col=%b, expected %h 1", data_out_2, collision_out,
                     (RDW != 0) ? 8'h3C : 8'h00);
        end
        checks++;
        if (data_out_1 !== ((RDW != 0) ? 8'h3C : 8'h00)) begin
            errors++;
            $display("FAIL rw_echo_p1: got d1=%h expected %h", data_out_1, (RDW != 0) ? 8'h3C : 8'h00);
        end
    endtask

    task automatic test_mid_reset();
        step(1, 1, 8'h40, 8'h5A, 0, 0, 8'h00, 8'h00);
        step(1, 0, 8'h40, 8'h00, 1, 1, 8'h42, 8'h77);
        repeat (LAT - 1) step_idle();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out_1, data_out_2} !== 16'h0000 || {valid_out_1, valid_out_2, collision_out} !== 3'b000
            || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async: got d1=%h d2=%h v1=%b v2=%b col=%b busy=%b, expected 0s busy 1",
                     data_out_1, data_out_2, valid_out_1, valid_out_2, collision_out, init_busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 1, 8'(i), 8'hEE, 1, 1, 8'h50, 8'(i));
            checks++;
            if (valid_out_1 !== 1'b0 || valid_out_2 !== 1'b0 || init_busy !== exp_busy || data_out_1 !== 8'h00) begin
                errors++;
                $display("FAIL reinit_cycle %0d: v1=%b v2=%b busy=%b d1=%h, expected 0 0 %b 00",
                         i, valid_out_1, valid_out_2, init_busy, data_out_1, exp_busy);
            end
        end
        step(1, 0, 8'h40, 8'h00, 1, 0, 8'h50, 8'h00);
        repeat (LAT - 1) step_idle();
        checks++;
        if (data_out_1 !== CLEAR || data_out_2 !== CLEAR || valid_out_1 !== 1'b1) begin
            errors++;
            $display("FAIL reinit_cleared: got d1=%h d2=%h v1=%b, expected %h %h 1",
                     data_out_1, data_out_2, valid_out_1, CLEAR, CLEAR);
        end
    endtask

    task automatic test_random();
        logic       e1, w1, e2, w2;
        logic [7:0] a1, a2, d1, d2;
        for (int i = 0; i < 800; i++) begin
            e1 = ($urandom_range(0, 3) != 0);
            e2 = ($urandom_range(0, 3) != 0);
            w1 = $urandom_range(0, 1) == 1;
            w2 = $urandom_range(0, 1) == 1;
            a1 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            step(e1, w1, a1, d1, e2, w2, a2, d2);
            checks++;
            if (data_out_1 !== exp_d1 || valid_out_1 !== exp_v1) begin
                errors++;
                $display("FAIL rand_p1 cycle %0d: got d1=%h v1=%b, expected %h %b", i, data_out_1, valid_out_1, exp_d1, exp_v1);
            end
            checks++;
            if (data_out_2 !== exp_d2 || valid_out_2 !== exp_v2) begin
                errors++;
                $display("FAIL rand_p2 cycle %0d: got d2=%h v2=%b, expected %h %b", i, data_out_2, valid_out_2, exp_d2, exp_v2);
            end
            checks++;
            if (collision_out !== exp_col || init_busy !== exp_busy) begin
                errors++;
                $display("FAIL rand_ctl cycle %0d: got col=%b busy=%b, expected %b %b", i, collision_out, init_busy, exp_col, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_collision_ww();
        test_collision_rw();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
